fb_port_arbiter: RTL and testbench

Two-requester arbiter and pipeline sequencer for the single-port frame-buffer block RAM behind the VGA scanout. The pixel-fetch port (driven from the VGA timing logic's x_val/y_val) and the host port (drawing engine or CPU, read/write) share one memory port. The pixel port has priority, and an optional starvation guard bounds host wait time. The block owns all memory control signals and returns read data with a fixed latency.

---
 rtl/fb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Pixel/host arbiter and fixed 3-cycle read pipeline for the single-port frame-buffer BRAM.
// Define FB_PORT_ARB_STARVE_GUARD_EN to bound host wait time under continuous pixel traffic.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              i_board_clock,
    input  logic              i_reset,
    input  logic              i_pix_req,
    input  logic [ADDR_W-1:0] i_pix_addr,
    output logic              o_pix_ack,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    logic              w_host_force;
    logic              w_pix_ack;
    logic              w_host_ack;
    logic              w_pix_acc;
    logic              w_host_acc;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_s1_rd;
    logic              r_s1_tag;
    logic              r_s2_rd;
    logic              r_s2_tag;
    logic              r_pix_valid;
    logic [DATA_W-1:0] r_pix_data;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

`ifdef FB_PORT_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0] r_starve_cnt;

    always_ff @(posedge i_board_clock) begin
        if (i_reset) begin
            r_starve_cnt <= 8'd0;
        end else if (w_host_acc) begin
            r_starve_cnt <= 8'd0;
        end else if (i_host_req && (r_starve_cnt != LP_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign w_host_force = (r_starve_cnt == LP_STARVE_MAX);
`else
    assign w_host_force = 1'b0;
`endif

    // Acks depend only on requests and registered starve state, never on the data path.
    assign w_pix_ack  = !i_reset && i_pix_req && !(i_host_req && w_host_force);
    assign w_host_ack = !i_reset && i_host_req && (!i_pix_req || w_host_force);
    assign w_pix_acc  = i_pix_req && w_pix_ack;
    assign w_host_acc = i_host_req && w_host_ack;

    always_ff @(posedge i_board_clock) begin
        if (i_reset) begin
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_s1_rd       <= 1'b0;
            r_s1_tag      <= 1'b0;
            r_s2_rd       <= 1'b0;
            r_s2_tag      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_mem_en <= w_pix_acc || w_host_acc;
            r_mem_we <= w_host_acc && i_host_we;
            r_s1_rd  <= w_pix_acc || (w_host_acc && !i_host_we);
            r_s1_tag <= w_host_acc;
            if (w_host_acc) begin
                r_mem_addr  <= i_host_addr;
                r_mem_wdata <= i_host_wdata;
            end else if (w_pix_acc) begin
                r_mem_addr <= i_pix_addr;
            end
            // Stage 2 lines up with mem_rdata from the BRAM.
            r_s2_rd       <= r_s1_rd;
            r_s2_tag      <= r_s1_tag;
            r_pix_valid   <= r_s2_rd && !r_s2_tag;
            r_host_rvalid <= r_s2_rd && r_s2_tag;
            if (r_s2_rd && !r_s2_tag) begin
                r_pix_data <= i_mem_rdata;
            end
            if (r_s2_rd && r_s2_tag) begin
                r_host_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_pix_ack     = w_pix_ack;
    assign o_host_ack    = w_host_ack;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_data    = r_pix_data;
    assign o_host_rvalid = r_host_rvalid;
    assign o_host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a behavioural write-first BRAM.
// Build with FB_PORT_ARB_STARVE_GUARD_EN defined to also exercise the starvation guard.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_req;
    logic [15:0] pix_addr;
    logic        pix_ack;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram     [0:65535];
    bit         written [0:65535];

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .i_board_clock (clk),
        .i_reset       (reset),
        .i_pix_req     (pix_req),
        .i_pix_addr    (pix_addr),
        .o_pix_ack     (pix_ack),
        .o_pix_valid   (pix_valid),
        .o_pix_data    (pix_data),
        .i_host_req    (host_req),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_wdata  (host_wdata),
        .o_host_ack    (host_ack),
        .o_host_rvalid (host_rvalid),
        .o_host_rdata  (host_rdata),
        .o_mem_en      (mem_en),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Write-first BRAM, one cycle read latency; unwritten words hold init_val(addr).
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
                mem_rdata         <= mem_wdata;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pix_req  = 1'b1;
        host_req = 1'b1;
        host_we  = 1'b0;
        pix_addr = 16'h0010;
        host_addr  = 16'h0011;
        host_wdata = 8'h00;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pix_ack !== 1'b0 || host_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_acks cyc%0d: got %b%b required 00", i, pix_ack, host_ack);
            end
            n_checks++;
            if (mem_en !== 1'b0 || pix_valid !== 1'b0 || host_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outs cyc%0d: en/pv/hv %b%b%b required 000",
                         i, mem_en, pix_valid, host_rvalid);
            end
            next_cycle();
        end
        reset    = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pix_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pix_ack: got %b required 1", pix_ack);
        end
        next_cycle();
        pix_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
                    n_fail++;
                    $display("FAIL first_mem_cmd: en %b we %b addr %h required 1 0 0010",
                             mem_en, mem_we, mem_addr);
                end
            end
            n_checks++;
            if (pix_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL first_pix_valid k%0d: got %b required %b", k, pix_valid, k == 3);
            end
            if (k == 3) begin
                n_checks++;
                if (pix_data !== init_val(16'h0010)) begin
                    n_fail++;
                    $display("FAIL first_pix_data: got %h required %h",
                             pix_data, init_val(16'h0010));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 12; j++) begin
            pix_req = (j < 8);
            if (j < 8) pix_addr = 16'(j);
            @(negedge clk);
            if (j < 8) begin
                n_checks++;
                if (pix_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ack j%0d: got %b required 1", j, pix_ack);
                end
            end
            n_checks++;
            if (pix_valid !== (j >= 3 && j <= 10)) begin
                n_fail++;
                $display("FAIL b2b_valid j%0d: got %b required %b", j, pix_valid,
                         (j >= 3 && j <= 10));
            end
            if (j >= 3 && j <= 10) begin
                n_checks++;
                if (pix_data !== init_val(16'(j - 3))) begin
                    n_fail++;
                    $display("FAIL b2b_data j%0d: got %h required %h", j, pix_data,
                             init_val(16'(j - 3)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        host_we   = 1'b0;
        host_addr = 16'h0200;
        for (int j = 0; j < 9; j++) begin
            pix_req  = (j < 4);
            host_req = (j < 5);
            pix_addr = 16'h0020 + 16'(j);
            @(negedge clk);
            if (j < 5) begin
                n_checks++;
                if (pix_ack !== (j < 4) || host_ack !== (j == 4)) begin
                    n_fail++;
                    $display("FAIL contend_acks j%0d: got pix %b host %b required %b %b",
                             j, pix_ack, host_ack, j < 4, j == 4);
                end
            end
            n_checks++;
            if (pix_valid !== (j >= 3 && j <= 6) || host_rvalid !== (j == 7)) begin
                n_fail++;
                $display("FAIL contend_valids j%0d: got pv %b hv %b required %b %b", j,
                         pix_valid, host_rvalid, (j >= 3 && j <= 6), j == 7);
            end
            if (j >= 3 && j <= 6) begin
                n_checks++;
                if (pix_data !== init_val(16'h0020 + 16'(j - 3))) begin
                    n_fail++;
                    $display("FAIL contend_pix_data j%0d: got %h required %h", j, pix_data,
                             init_val(16'h0020 + 16'(j - 3)));
                end
            end
            if (j == 7) begin
                n_checks++;
                if (host_rdata !== init_val(16'h0200)) begin
                    n_fail++;
                    $display("FAIL contend_host_data: got %h required %h", host_rdata,
                             init_val(16'h0200));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_host_write_read();
        pix_req    = 1'b0;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 16'h0100;
        host_wdata = 8'hA5;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) host_we = 1'b0;
            if (c == 2) host_req = 1'b0;
            @(negedge clk);
            if (c < 2) begin
                n_checks++;
                if (host_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_rd_ack c%0d: got %b required 1", c, host_ack);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0100 ||
                    mem_wdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL wr_cmd: en %b we %b addr %h wdata %h required 1 1 0100 a5",
                             mem_en, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin
                    n_fail++;
                    $display("FAIL idle_hold: en %b we %b addr %h required 0 0 0100",
                             mem_en, mem_we, mem_addr);
                end
            end
            n_checks++;
            if (host_rvalid !== (c == 4)) begin
                n_fail++;
                $display("FAIL wr_rd_rvalid c%0d: got %b required %b", c, host_rvalid, c == 4);
            end
            if (c == 4) begin
                n_checks++;
                if (host_rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL wr_rd_data: got %h required a5", host_rdata);
                end
            end
            next_cycle();
        end
    endtask

`ifdef FB_PORT_ARB_STARVE_GUARD_EN
    task automatic test_starvation();
        pix_req   = 1'b1;
        host_req  = 1'b1;
        host_we   = 1'b0;
        pix_addr  = 16'h0060;
        host_addr = 16'h0070;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            n_checks++;
            if (host_ack !== ((j % 16) == 15) || pix_ack !== ((j % 16) != 15)) begin
                n_fail++;
                $display("FAIL starve_acks j%0d: got pix %b host %b required %b %b", j,
                         pix_ack, host_ack, (j % 16) != 15, (j % 16) == 15);
            end
            next_cycle();
        end
        pix_req  = 1'b0;
        host_req = 1'b0;
        repeat (4) next_cycle();
    endtask
`endif

    task automatic test_reset_in_flight();
        pix_req  = 1'b1;
        pix_addr = 16'h0030;
        @(negedge clk);
        n_checks++;
        if (pix_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_pix_ack: got %b required 1", pix_ack);
        end
        next_cycle();
        pix_req   = 1'b0;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h0040;
        @(negedge clk);
        n_checks++;
        if (host_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_host_ack: got %b required 1", host_ack);
        end
        next_cycle();
        reset    = 1'b1;
        pix_req  = 1'b1;
        host_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pix_ack !== 1'b0 || host_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_acks: got %b%b required 00", pix_ack, host_ack);
        end
        next_cycle();
        reset    = 1'b0;
        pix_req  = 1'b0;
        host_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (pix_valid !== 1'b0 || host_rvalid !== 1'b0 || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL flushed k%0d: pv %b hv %b en %b required 000", k, pix_valid,
                         host_rvalid, mem_en);
            end
            if (k == 0) begin
                n_checks++;
                if (pix_data !== 8'h00 || host_rdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_data: pix %h host %h required 00 00",
                             pix_data, host_rdata);
                end
            end
            next_cycle();
        end
        pix_req  = 1'b1;
        pix_addr = 16'h0050;
        @(negedge clk);
        n_checks++;
        if (pix_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ack: got %b required 1", pix_ack);
        end
        next_cycle();
        pix_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (pix_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL post_reset_valid k%0d: got %b required %b", k, pix_valid, k == 3);
            end
            if (k == 3) begin
                n_checks++;
                if (pix_data !== init_val(16'h0050)) begin
                    n_fail++;
                    $display("FAIL post_reset_data: got %h required %h", pix_data,
                             init_val(16'h0050));
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_contention();
        test_host_write_read();
`ifdef FB_PORT_ARB_STARVE_GUARD_EN
        test_starvation();
`endif
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
